kernel_launcher: RTL and testbench

Host-side sequencer that sits directly upstream of the `gpu` top. It accepts queued kernel launch requests, each carrying a thread count, and runs them one at a time. For each launch it resets the GPU, writes the device control register, holds `start`, and waits for `done`. It then returns a per-launch response carrying the cycle count and a timeout flag.

---
 rtl/kernel_launcher.sv | 192 +++++++++++++++++++
 tb/tb_kernel_launcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_launcher.sv
// kernel_launcher: queues kernel launch requests and runs them one at a time
// on the downstream GPU (reset, DCR write, start, wait for done), returning a
// per-launch response with the run-cycle count and a timeout flag.
module kernel_launcher #(
  parameter int QUEUE_DEPTH      = 4,
  parameter int CYCLE_COUNT_BITS = 16,
  parameter int TIMEOUT_CYCLES   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_thread_count,
  output logic                          cmd_ready,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic                          busy,
  output logic                          gpu_reset,
  output logic                          gpu_start,
  output logic                          gpu_device_control_write_enable,
  output logic [7:0]                    gpu_device_control_data,
  input  logic                          gpu_done,
  output logic                          rsp_valid,
  output logic [CYCLE_COUNT_BITS-1:0]   rsp_cycles,
  output logic                          rsp_timeout,
  input  logic                          rsp_ready
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CCB   = CYCLE_COUNT_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRST,
    ST_CONFIG,
    ST_RUN,
    ST_RESPOND
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           fifo_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CCB-1:0]       run_cnt_q, run_cnt_d;
  logic [CCB:0]         run_cnt_inc;
  logic                 gpu_reset_q, gpu_reset_d;
  logic                 gpu_start_q, gpu_start_d;
  logic                 dcr_we_q, dcr_we_d;
  logic [7:0]           dcr_data_q, dcr_data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [CCB-1:0]       rsp_cycles_q, rsp_cycles_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 push, pop;
  logic [7:0]           head;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CCB-1:0] sat_inc(input logic [CCB-1:0] v);
    return (&v) ? v : v + CCB'(1);
  endfunction

  assign cmd_ready   = (count_q != CNT_W'(QUEUE_DEPTH));
  assign queue_count = count_q;
  assign busy        = (state_q != ST_IDLE) || (count_q != '0);
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state_q == ST_CONFIG);
  assign head        = fifo_q[rd_ptr_q];
  assign run_cnt_inc = {1'b0, run_cnt_q} + (CCB+1)'(1);

  assign gpu_reset                       = gpu_reset_q;
  assign gpu_start                       = gpu_start_q;
  assign gpu_device_control_write_enable = dcr_we_q;
  assign gpu_device_control_data         = dcr_data_q;
  assign rsp_valid                       = rsp_valid_q;
  assign rsp_cycles                      = rsp_cycles_q;
  assign rsp_timeout                     = rsp_timeout_q;

  // Queue pointers and occupancy; pop only happens on the CONFIG edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Launch sequencer; outputs are computed for the state being entered so
  // every GPU-facing and response output comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    gpu_reset_d   = 1'b0;
    gpu_start_d   = 1'b0;
    dcr_we_d      = 1'b0;
    dcr_data_d    = dcr_data_q;
    rsp_valid_d   = 1'b0;
    rsp_cycles_d  = rsp_cycles_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d     = ST_GRST;
          gpu_reset_d = 1'b1;
        end
      end
      ST_GRST: begin
        state_d    = ST_CONFIG;
        dcr_we_d   = 1'b1;
        dcr_data_d = head;
      end
      ST_CONFIG: begin
        run_cnt_d = '0;
        if (head == 8'd0) begin
          // Zero threads: nothing to run, report an empty launch.
          state_d       = ST_RESPOND;
          rsp_valid_d   = 1'b1;
          rsp_cycles_d  = '0;
          rsp_timeout_d = 1'b0;
        end else begin
          state_d     = ST_RUN;
          gpu_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (gpu_done) begin
          state_d       = ST_RESPOND;
          rsp_valid_d   = 1'b1;
          rsp_cycles_d  = run_cnt_q;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) &&
                     (run_cnt_inc == (CCB+1)'(TIMEOUT_CYCLES))) begin
          state_d       = ST_RESPOND;
          rsp_valid_d   = 1'b1;
          rsp_cycles_d  = CCB'(TIMEOUT_CYCLES);
          rsp_timeout_d = 1'b1;
        end else begin
          gpu_start_d = 1'b1;
          run_cnt_d   = sat_inc(run_cnt_q);
        end
      end
      ST_RESPOND: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; reset holds the GPU in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      gpu_reset_q   <= 1'b1;
      gpu_start_q   <= 1'b0;
      dcr_we_q      <= 1'b0;
      dcr_data_q    <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      gpu_reset_q   <= gpu_reset_d;
      gpu_start_q   <= gpu_start_d;
      dcr_we_q      <= dcr_we_d;
      dcr_data_q    <= dcr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_cycles_q  <= rsp_cycles_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Queue storage and run counter need no reset: pointers gate the storage
  // and the counter is cleared in CONFIG before every run.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_thread_count;
    run_cnt_q <= run_cnt_d;
  end

endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: three instances (plain, 4-bit saturating
// counter, timeout of 10) share the command stream; each has its own GPU
// stand-in and a transcript model of the expected per-cycle behaviour.
module tb_kernel_launcher;

  localparam int QD  = 4;
  localparam int QW  = $clog2(QD) + 1;
  localparam int P_IDLE = 0;
  localparam int P_GRST = 1;
  localparam int P_CFG  = 2;
  localparam int P_RUN  = 3;
  localparam int P_RSP  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_tc;
  logic       rsp_ready;
  int         len_lo;
  int         len_hi;
  int         n_chk = 0;
  int         n_err = 0;
  int         b0, b1, b2;

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int TO   = (g == 2) ? 10 : 0;
    localparam int CB   = (g == 1) ? 4 : 16;
    localparam int MAXC = (1 << CB) - 1;

    logic [QW-1:0] queue_count;
    logic          cmd_ready, busy, gpu_reset, gpu_start, dcr_we;
    logic [7:0]    dcr_data;
    logic          rsp_valid, rsp_timeout;
    logic [CB-1:0] rsp_cycles;
    logic          gpu_done = 1'b0;

    kernel_launcher #(
      .QUEUE_DEPTH(QD), .CYCLE_COUNT_BITS(CB), .TIMEOUT_CYCLES(TO)
    ) dut (
      .clk(clk), .reset(rst),
      .cmd_valid(cmd_valid), .cmd_thread_count(cmd_tc), .cmd_ready(cmd_ready),
      .queue_count(queue_count), .busy(busy),
      .gpu_reset(gpu_reset), .gpu_start(gpu_start),
      .gpu_device_control_write_enable(dcr_we),
      .gpu_device_control_data(dcr_data), .gpu_done(gpu_done),
      .rsp_valid(rsp_valid), .rsp_cycles(rsp_cycles),
      .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready)
    );

    // GPU stand-in: done rises after run_len cycles of start, sticky until reset.
    int run_len = 0;
    int run_cnt = 0;
    always @(posedge clk) begin
      #1;
      if (gpu_reset) begin
        run_cnt  = 0;
        gpu_done = 1'b0;
      end else if (gpu_start) begin
        gpu_done = (run_cnt >= run_len);
        run_cnt++;
      end
    end

    // Transcript model: each launch expands into the cycle sequence it must show.
    int         seq[$];
    logic [7:0] mq[$];
    logic       rst_tail = 1'b0;
    int         exp_cyc = 0;
    logic       exp_to = 1'b0;
    int         n_rsp = 0;
    int         rsp_seen = 0;
    int         last_cyc = -1;
    int         dut_cyc = -1;
    int         dut_to = -1;
    always @(negedge clk) begin : p_model
      int   kind, sz, nrun, rl;
      logic acc;
      logic [7:0] tc;
      if (rst) begin
        chk($sformatf("i%0d.rst.gpu_reset", g), gpu_reset, 1);
        chk($sformatf("i%0d.rst.gpu_start", g), gpu_start, 0);
        chk($sformatf("i%0d.rst.dcr_we", g), dcr_we, 0);
        chk($sformatf("i%0d.rst.dcr_data", g), dcr_data, 0);
        chk($sformatf("i%0d.rst.rsp_valid", g), rsp_valid, 0);
        chk($sformatf("i%0d.rst.rsp_cycles", g), rsp_cycles, 0);
        chk($sformatf("i%0d.rst.rsp_timeout", g), rsp_timeout, 0);
        chk($sformatf("i%0d.rst.queue_count", g), queue_count, 0);
        chk($sformatf("i%0d.rst.cmd_ready", g), cmd_ready, 1);
        chk($sformatf("i%0d.rst.busy", g), busy, 0);
        mq.delete();
        seq.delete();
        rst_tail = 1'b1;
      end else begin
        kind = (seq.size() != 0) ? seq[0] : P_IDLE;
        sz   = mq.size();
        chk($sformatf("i%0d.queue_count", g), queue_count, sz);
        chk($sformatf("i%0d.cmd_ready", g), cmd_ready, (sz != QD));
        chk($sformatf("i%0d.busy", g), busy, (kind != P_IDLE) || (sz != 0));
        chk($sformatf("i%0d.gpu_reset", g), gpu_reset,
            (kind == P_GRST) || (kind == P_IDLE && rst_tail));
        chk($sformatf("i%0d.gpu_start", g), gpu_start, (kind == P_RUN));
        chk($sformatf("i%0d.dcr_we", g), dcr_we, (kind == P_CFG));
        chk($sformatf("i%0d.rsp_valid", g), rsp_valid, (kind == P_RSP));
        if (kind == P_CFG)
          chk($sformatf("i%0d.dcr_data", g), dcr_data, mq[0]);
        if (kind == P_RSP) begin
          chk($sformatf("i%0d.rsp_cycles", g), rsp_cycles, exp_cyc);
          chk($sformatf("i%0d.rsp_timeout", g), rsp_timeout, exp_to);
        end
        if (rsp_valid && rsp_ready) begin
          rsp_seen++;
          dut_cyc = int'(rsp_cycles);
          dut_to  = int'(rsp_timeout);
        end
        rst_tail = 1'b0;
        acc = cmd_valid && (sz != QD);
        if (kind == P_CFG) void'(mq.pop_front());
        if (acc) mq.push_back(cmd_tc);
        if (kind == P_IDLE) begin
          if (sz != 0) begin
            tc = mq[0];
            rl = int'($urandom_range(len_hi, len_lo));
            run_len = rl;
            if (tc == 8'd0) begin
              nrun = 0; exp_cyc = 0; exp_to = 1'b0;
            end else if (TO != 0 && rl >= TO) begin
              nrun = TO; exp_cyc = TO; exp_to = 1'b1;
            end else begin
              nrun = rl + 1; exp_cyc = (rl > MAXC) ? MAXC : rl; exp_to = 1'b0;
            end
            seq.push_back(P_GRST);
            seq.push_back(P_CFG);
            repeat (nrun) seq.push_back(P_RUN);
            seq.push_back(P_RSP);
          end
        end else if (kind != P_RSP || rsp_ready) begin
          if (kind == P_RSP) begin
            n_rsp++;
            last_cyc = exp_cyc;
          end
          void'(seq.pop_front());
        end
      end
    end
  end

  task automatic snap();
    b0 = g_inst[0].n_rsp;
    b1 = g_inst[1].n_rsp;
    b2 = g_inst[2].n_rsp;
  endtask

  task automatic drive_cmd(input logic [7:0] v);
    cmd_valid = 1'b1;
    cmd_tc    = v;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_n(input int k, input int budget);
    int cnt = 0;
    while ((g_inst[0].n_rsp < b0 + k || g_inst[1].n_rsp < b1 + k ||
            g_inst[2].n_rsp < b2 + k) && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk("wait_rsp_in_budget", (cnt < budget), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int cnt = 0;
    @(negedge clk);
    while ((g_inst[0].busy || g_inst[1].busy || g_inst[2].busy) && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk("wait_idle_in_budget", (cnt < budget), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    int seen0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_tc = 8'd0; rsp_ready = 1'b1;
    len_lo = 0; len_hi = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Single launch of 8 threads, GPU done after 20 run cycles.
    len_lo = 20; len_hi = 20;
    snap(); drive_cmd(8'd8); wait_n(1, 200);
    chk("single.A.cycles", g_inst[0].dut_cyc, 20);
    chk("single.A.timeout", g_inst[0].dut_to, 0);
    chk("single.A.model", g_inst[0].last_cyc, 20);
    chk("single.B.saturated", g_inst[1].dut_cyc, 15);
    chk("single.B.model", g_inst[1].last_cyc, 15);
    chk("single.C.cycles", g_inst[2].dut_cyc, 10);
    chk("single.C.timeout", g_inst[2].dut_to, 1);

    // Zero-thread launch: no run, empty response.
    snap(); drive_cmd(8'd0); wait_n(1, 100);
    chk("zero.A.cycles", g_inst[0].dut_cyc, 0);
    chk("zero.C.timeout", g_inst[2].dut_to, 0);

    // GPU already done on the first run cycle.
    len_lo = 0; len_hi = 0;
    snap(); drive_cmd(8'd5); wait_n(1, 100);
    chk("done_first.A.cycles", g_inst[0].dut_cyc, 0);
    chk("done_first.C.timeout", g_inst[2].dut_to, 0);

    // Fill the queue while the sequencer is stalled in its response.
    len_lo = 3; len_hi = 3;
    rsp_ready = 1'b0;
    snap(); drive_cmd(8'd1);
    cnt = 0;
    @(negedge clk);
    while (!g_inst[0].rsp_valid && cnt < 50) begin @(negedge clk); cnt++; end
    chk("stall.reach_rsp", (cnt < 50), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) drive_cmd(8'(11 + i));
    @(negedge clk);
    chk("full.A.queue_count", g_inst[0].queue_count, 4);
    chk("full.A.cmd_ready", g_inst[0].cmd_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_n(5, 600);
    chk("full.A.last_cycles", g_inst[0].dut_cyc, 3);

    // Randomized traffic with mixed run lengths, including timeouts on C.
    len_lo = 0; len_hi = 25;
    for (int i = 0; i < 500; i++) begin
      cmd_valid = ($urandom_range(2, 0) == 0);
      cmd_tc    = ($urandom_range(5, 0) == 0) ? 8'd0 : 8'($urandom);
      rsp_ready = ($urandom_range(3, 0) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(3000);

    // Reset in the middle of a run with two launches still queued.
    len_lo = 50; len_hi = 50;
    drive_cmd(8'd3); drive_cmd(8'd4); drive_cmd(8'd5);
    cnt = 0;
    @(negedge clk);
    while (!(g_inst[0].gpu_start && g_inst[0].queue_count == 2) && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    chk("midreset.reach_run", (cnt < 30), 1);
    @(posedge clk); #1;
    seen0 = g_inst[0].rsp_seen;
    rst = 1'b1;
    #1;
    chk("midreset.async.gpu_reset", g_inst[0].gpu_reset, 1);
    chk("midreset.async.gpu_start", g_inst[0].gpu_start, 0);
    chk("midreset.async.queue_count", g_inst[0].queue_count, 0);
    chk("midreset.async.cmd_ready", g_inst[0].cmd_ready, 1);
    chk("midreset.async.busy", g_inst[0].busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (80) begin @(posedge clk); #1; end
    chk("midreset.no_response", g_inst[0].rsp_seen, seen0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
